ps2_frame_rx: RTL and testbench
===============================

# ps2_frame_rx

PS/2 device-to-host frame receiver. It sits directly upstream of the receive/validate/translate stage and feeds it scan-code bytes. The block synchronises and deglitches `ps2c`, samples `ps2d` on filtered falling edges, and assembles the 11-bit frame (start, 8 data bits LSB first, odd parity, stop). It then presents the byte with a one-cycle done strobe plus parity and framing error flags.

## Interface
- `FILTER_LEN`, 8: number of consecutive identical `ps2c` samples required to change the filtered clock level.
- `TIMEOUT_CYC`, 100000: idle-clock limit inside a frame, in clk cycles (2 ms at 50 MHz). Used only with `PS2_RX_TIMEOUT_EN`.
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2d`  in  1  PS/2 data line, asynchronous.
- `ps2c`  in  1  PS/2 clock line, asynchronous.
- `rx_en`  in  1  receive enable; gates only the start of a new frame.
- `dout`  out  8  received data byte.
- `rx_done_tick`  out  1  one-cycle strobe: frame complete; `dout` and the flags are valid.
- `parity_err`  out  1  last frame failed the odd-parity check.
- `frame_err`  out  1  last frame had start≠0 or stop≠1, or timed out (timeout only with the macro).

## Operation
- Synchronisation:
  - `ps2c` and `ps2d` each pass through a 2-FF synchroniser.
  - Synchronised `ps2c` feeds a `FILTER_LEN`-bit shift register.
  - The filtered clock goes to 1 when the register is all ones and to 0 when it is all zeros; otherwise it holds.
  - `fall_tick` = previous filtered level & ~current filtered level. It is high for one cycle.
- Frame register `b_reg[10:0]` shifts right on each accepted `fall_tick`: `b_reg <= {ps2d_sync, b_reg[10:1]}`.
- Bit counter `n` is 4 bits wide.
- FSM states:
  - **IDLE**: on `fall_tick` && `rx_en`, shift the start bit, set `n=9`, go to DPS. A `fall_tick` while `rx_en`=0 is ignored.
  - **DPS**: on `fall_tick`, shift. If `n==0`, go to LOAD; else `n<=n-1`. Lowering `rx_en` mid-frame does not abort the frame.
  - **LOAD**: lasts exactly one cycle, then returns to IDLE unconditionally.
- On the transition into LOAD:
  - `dout <= b_reg[8:1]` of the completed frame.
  - `parity_err <= ~^b_reg[9:1]` (the error is set when the count of ones in data plus parity is even).
  - `frame_err <= b_reg[0] | ~b_reg[10]`.
- `rx_done_tick` = (state == LOAD), decoded from the state register.
- The strobe fires even on error frames; downstream decides validity from the flags.
- `dout`, `parity_err` and `frame_err` hold until the next LOAD or timeout.
- Reset values, asynchronous:
  - FSM in IDLE; `n=0`; `b_reg=0`.
  - Filter register all ones; filtered level 1; synchronisers 1.
  - `dout=0x00`; `rx_done_tick=0`; `parity_err=0`; `frame_err=0`.
- Reset asserted mid-frame discards the partial frame with no strobe. The next frame starts cleanly after reset releases.

## Timing
- Edge detection latency: 2 (synchroniser) + `FILTER_LEN` cycles from the `ps2c` fall to `fall_tick`.
- `ps2d` is sampled in the `fall_tick` cycle. PS/2 holds data stable across the falling edge for at least 5 µs, well beyond the 10-cycle latency.
- `rx_done_tick` goes high in the cycle after the stop-bit `fall_tick`, for exactly one cycle.
- Back-to-back frames: LOAD lasts one cycle, so the next start bit (≥60 µs later) is always seen in IDLE.
- Glitches on `ps2c` shorter than `FILTER_LEN` cycles produce no tick.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A 17-bit counter clears on every `fall_tick` and on entering DPS, and increments while in DPS.
  - When it reaches `TIMEOUT_CYC-1`, the FSM returns to IDLE, `frame_err` is set to 1, `parity_err` is cleared, `dout` holds, and no `rx_done_tick` fires.
- Undefined:
  - No counter exists.
  - The FSM waits in DPS indefinitely for further edges, and a truncated frame merges with the following one.

## Structure
- Package `ps2_pkg` holds:
  - The state enum {IDLE, DPS, LOAD}.
  - `FRAME_BITS=11`.
  - The default `FILTER_LEN` and `TIMEOUT_CYC` constants.
- Sub-module `ps2_clk_filter` handles the synchroniser, filter and `fall_tick` generation. The top instantiates it once; the FSM, datapath and timeout live in the top.

## Test plan
- Frame 0x1C, parity 0, stop 1, `rx_en`=1 → one `rx_done_tick`, `dout`=0x1C, `parity_err`=0, `frame_err`=0.
- Frame 0xF0, parity 1, followed 60 µs later by frame 0x1C → two strobes, `dout` sequence 0xF0 then 0x1C, no errors.
- Frame 0x1C with parity 1 → strobe, `dout`=0x1C, `parity_err`=1. Frame 0x1C with stop 0 → strobe, `frame_err`=1.
- `rx_en`=0 during the start edge → no strobe, FSM stays in IDLE. A 3-cycle low glitch on `ps2c` → no `fall_tick`, `b_reg` unchanged.
- With `PS2_RX_TIMEOUT_EN`: 5 clock edges, then the line idles → after `TIMEOUT_CYC` cycles the FSM is in IDLE with `frame_err`=1 and no strobe; the following full 0x1C frame is received correctly.
- `reset` pulsed low after 6 bits → all outputs 0, no strobe; the next full frame 0x1C is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DPS  = 2'd1,
        LOAD = 2'd2
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Default build-time constants
    localparam int FILTER_LEN_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on ps2c/ps2d, a FILTER_LEN-sample
// level filter on the clock line, and a one-cycle tick on each filtered fall.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_sync,
    output logic fall_tick
);

    logic [1:0]            c_sync_q;
    logic [1:0]            d_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic [FILTER_LEN-1:0] filt_d;
    logic                  lvl_q;
    logic                  lvl_d;

    // Two-stage synchronisers; lines idle high, so reset to 1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
        end
    end

    // Filter shift and current filtered level: change only on a unanimous register
    always_comb begin
        filt_d = {c_sync_q[1], filt_q[FILTER_LEN-1:1]};
        lvl_d  = lvl_q;
        if (&filt_q) begin
            lvl_d = 1'b1;
        end else if (~|filt_q) begin
            lvl_d = 1'b0;
        end
    end

    // Filter register and previous filtered level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_q <= '1;
            lvl_q  <= 1'b1;
        end else begin
            filt_q <= filt_d;
            lvl_q  <= lvl_d;
        end
    end

    assign fall_tick = lvl_q & ~lvl_d;
    assign ps2d_sync = d_sync_q[1];

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: assembles start/8 data/odd parity/stop
// frames sampled on filtered ps2c falling edges and presents the byte with a
// one-cycle done strobe plus parity and framing error flags.
// Optional in-frame idle timeout: define PS2_RX_TIMEOUT_EN.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    state_t                  state_q;
    logic [3:0]              n_q;
    logic [FRAME_BITS-1:0]   b_q;
    logic [FRAME_BITS-1:0]   b_d;
    logic [7:0]              dout_q;
    logic                    perr_q;
    logic                    ferr_q;
    logic                    ps2d_sync;
    logic                    fall_tick;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .ps2d_sync (ps2d_sync),
        .fall_tick (fall_tick)
    );

    // Frame word after shifting in the current data sample (LSB arrives first)
    assign b_d = {ps2d_sync, b_q[FRAME_BITS-1:1]};

`ifdef PS2_RX_TIMEOUT_EN
    localparam logic [16:0] TMO_LAST = 17'(TIMEOUT_CYC - 1);
    logic [16:0] tmo_q;

    // Idle-clock counter: runs only between edges while inside a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else if (state_q == DPS && !fall_tick) begin
            tmo_q <= tmo_q + 17'd1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    logic tmo_cfg_unused;
    assign tmo_cfg_unused = (TIMEOUT_CYC > 0);
`endif

    // Receive FSM with frame register, bit counter and registered result flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall_tick && rx_en) begin
                        b_q     <= b_d;
                        n_q     <= 4'(FRAME_BITS - 2);
                        state_q <= DPS;
                    end
                end
                DPS: begin
                    if (fall_tick) begin
                        b_q <= b_d;
                        if (n_q == 4'd0) begin
                            state_q <= LOAD;
                            dout_q  <= b_d[8:1];
                            perr_q  <= ~^b_d[9:1];
                            ferr_q  <= b_d[0] | ~b_d[FRAME_BITS-1];
                        end else begin
                            n_q <= n_q - 4'd1;
                        end
                    end
`ifdef PS2_RX_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        // Abandoned frame: flag it, keep the last good byte, no strobe
                        state_q <= IDLE;
                        ferr_q  <= 1'b1;
                        perr_q  <= 1'b0;
                    end
`endif
                end
                LOAD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_done_tick = (state_q == LOAD);
    assign dout         = dout_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: frame-level reference model plus
// directed and randomized PS/2 frames.
module tb_ps2_frame_rx;
    import ps2_pkg::*;

    localparam int FL   = 8;
    localparam int TMO  = 400;
    localparam int PER  = 10;
    localparam int HALF = 30;
    // ps2c fall -> fall_tick is 2+FL cycles, strobe one cycle later
    localparam int LAT  = 2 + FL + 1;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ps2d  = 1'b1;
    logic       ps2c  = 1'b1;
    logic       rx_en = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;

    ps2_frame_rx #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2d         (ps2d),
        .ps2c         (ps2c),
        .rx_en        (rx_en),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err)
    );

    always #(PER/2) clk = ~clk;

    typedef struct {
        time        due;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m_dout = 8'h00;
    logic        m_pe = 1'b0;
    logic        m_fe = 1'b0;
    bit          flags_free = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          strobes = 0;
    int          ticks = 0;
    logic [10:0] last_frame = 11'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the frame-level model every cycle
    always @(negedge clk) begin
        bit exp_done;
        exp_done = 1'b0;
        if (q.size() > 0 && q[0].due == $time) begin
            exp_done = 1'b1;
            m_dout   = q[0].d;
            m_pe     = q[0].pe;
            m_fe     = q[0].fe;
            void'(q.pop_front());
        end
        chk("rx_done_tick", 32'(rx_done_tick), 32'(exp_done));
        if (rx_done_tick) strobes++;
        if (dut.fall_tick) ticks++;
        if (!flags_free) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("parity_err", 32'(parity_err), 32'(m_pe));
            chk("frame_err", 32'(frame_err), 32'(m_fe));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p,
                                        input logic s, input logic st);
        return {st, p, d, s};
    endfunction

    // Drive nbits of a frame, LSB first; data changes while ps2c is high
    task automatic send_bits(input logic [10:0] fr, input int nbits, input bit en,
                             input bit toggle_en, input bit glitch);
        exp_t e;
        int   len;
        int   ones;
        rx_en = en;
        for (int i = 0; i < nbits; i++) begin
            ps2d = fr[i];
            if (i > 0 && en && toggle_en) rx_en = 1'($urandom_range(0, 1));
            if (glitch && $urandom_range(0, 3) == 0) begin
                step(12);
                len  = $urandom_range(1, FL - 1);
                ps2c = 1'b0;
                step(len);
                ps2c = 1'b1;
                step(HALF - 12 - len);
            end else begin
                step(HALF);
            end
            ps2c = 1'b0;
            if (i == 10 && nbits == 11 && en) begin
                ones  = $countones(fr[8:1]) + int'(fr[9]);
                e.due = $time - 1 + LAT * PER;
                e.d   = fr[8:1];
                e.pe  = (ones % 2 == 0);
                e.fe  = (fr[0] == 1'b1) || (fr[10] == 1'b0);
                q.push_back(e);
                last_frame = fr;
            end
            step(HALF);
            ps2c = 1'b1;
        end
    endtask

    task automatic send(input logic [10:0] fr);
        send_bits(fr, 11, 1'b1, 1'b0, 1'b0);
        step(2 * HALF);
    endtask

    initial begin
        int s0;
        int t0;
        logic [7:0] d;
        logic p;

        #1 reset = 1'b0;
        step(3);
        chk("reset_dout", 32'(dout), 32'h00);
        chk("reset_perr", 32'(parity_err), 32'h0);
        chk("reset_ferr", 32'(frame_err), 32'h0);
        chk("reset_done", 32'(rx_done_tick), 32'h0);
        reset = 1'b1;
        step(5);

        // Good frame 0x1C (3 ones, parity 0)
        s0 = strobes;
        send(mk(8'h1C, 1'b0, 1'b0, 1'b1));
        chk("f1C_strobes", 32'(strobes - s0), 32'd1);
        chk("f1C_dout", 32'(dout), 32'h1C);
        chk("f1C_perr", 32'(parity_err), 32'h0);
        chk("f1C_ferr", 32'(frame_err), 32'h0);

        // 0xF0 (parity 1) then 0x1C
        s0 = strobes;
        send(mk(8'hF0, 1'b1, 1'b0, 1'b1));
        chk("fF0_dout", 32'(dout), 32'hF0);
        send(mk(8'h1C, 1'b0, 1'b0, 1'b1));
        chk("b2b_strobes", 32'(strobes - s0), 32'd2);
        chk("b2b_dout", 32'(dout), 32'h1C);
        chk("b2b_err", 32'({parity_err, frame_err}), 32'h0);

        // Bad parity, then bad stop
        send(mk(8'h1C, 1'b1, 1'b0, 1'b1));
        chk("perr_dout", 32'(dout), 32'h1C);
        chk("perr_flag", 32'(parity_err), 32'h1);
        s0 = strobes;
        send(mk(8'h1C, 1'b0, 1'b0, 1'b0));
        chk("stop_strobe", 32'(strobes - s0), 32'd1);
        chk("stop_ferr", 32'(frame_err), 32'h1);
        chk("stop_perr", 32'(parity_err), 32'h0);

        // Receive disabled across the whole frame: ignored
        s0 = strobes;
        send_bits(mk(8'hA5, 1'b1, 1'b0, 1'b1), 11, 1'b0, 1'b0, 1'b0);
        step(2 * HALF);
        chk("rxen0_strobe", 32'(strobes - s0), 32'd0);
        chk("rxen0_idle", 32'(dut.state_q == IDLE), 32'd1);

        // 3-cycle low glitch on an idle line
        t0 = ticks;
        ps2c = 1'b0;
        step(3);
        ps2c = 1'b1;
        step(40);
        chk("glitch_ticks", 32'(ticks - t0), 32'd0);
        chk("glitch_breg", 32'(dut.b_q), 32'(last_frame));

`ifdef PS2_RX_TIMEOUT_EN
        // Truncated frame: 5 edges, then the line idles
        s0 = strobes;
        send_bits(mk(8'h55, 1'b1, 1'b0, 1'b1), 5, 1'b1, 1'b0, 1'b0);
        flags_free = 1'b1;
        step(TMO + 40);
        m_fe = 1'b1;
        m_pe = 1'b0;
        flags_free = 1'b0;
        chk("tmo_strobe", 32'(strobes - s0), 32'd0);
        chk("tmo_idle", 32'(dut.state_q == IDLE), 32'd1);
        chk("tmo_ferr", 32'(frame_err), 32'h1);
        send(mk(8'h1C, 1'b0, 1'b0, 1'b1));
        chk("tmo_next_dout", 32'(dout), 32'h1C);
        chk("tmo_next_err", 32'({parity_err, frame_err}), 32'h0);
`endif

        // Reset after 6 bits of a frame
        s0 = strobes;
        send_bits(mk(8'h3C, 1'b1, 1'b0, 1'b1), 6, 1'b1, 1'b0, 1'b0);
        step(5);
        reset = 1'b0;
        q.delete();
        m_dout = 8'h00;
        m_pe = 1'b0;
        m_fe = 1'b0;
        step(3);
        chk("rst_mid_dout", 32'(dout), 32'h00);
        chk("rst_mid_flags", 32'({parity_err, frame_err}), 32'h0);
        reset = 1'b1;
        step(20);
        chk("rst_mid_strobe", 32'(strobes - s0), 32'd0);
        send(mk(8'h1C, 1'b0, 1'b0, 1'b1));
        chk("rst_next_dout", 32'(dout), 32'h1C);
        chk("rst_next_err", 32'({parity_err, frame_err}), 32'h0);

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            d = 8'($urandom);
            p = ~^d;
            if ($urandom_range(0, 3) == 0) p = ~p;
            send_bits(mk(d, p, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) != 0)),
                      11, 1'($urandom_range(0, 6) != 0), 1'b1, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                ps2c = 1'b0;
                step($urandom_range(1, FL - 1));
                ps2c = 1'b1;
            end
            step($urandom_range(2 * HALF, 6 * HALF));
        end

        step(50);
        chk("pending_strobes", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(PER * 95000);
        $display("FAIL watchdog: simulation did not finish within budget");
        $fatal(1);
    end

endmodule
